// File: rtl/refill_pkg.sv
`default_nettype none
// ============================================================================
// Module      : refill_pkg
// Description : Shared state encoding and defaults for the cache refill FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package refill_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;
    localparam int CNT_WIDTH              = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2
    } state_t;

endpackage : refill_pkg
`default_nettype wire

// File: rtl/mem_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_refill_ctrl
// Description : Single-outstanding cache miss refill controller with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_refill_ctrl
    import refill_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     miss_i,
    input  logic                     we_i,
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wdata_o,
    input  logic                     mem_ready_i,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
    output logic                     fill_valid_o,
    output logic [ADDRESS_WIDTH-1:0] fill_addr_o,
    output logic [DATA_WIDTH-1:0]    fill_data_o,
    output logic                     stall_o,
    output logic                     err_o
);

    // Timeout fires on the TIMEOUT_CYCLES-th consecutive REQ cycle without ready.
    localparam logic [CNT_WIDTH-1:0] c_TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                     r_state;
    state_t                     w_next_state;
    logic [CNT_WIDTH-1:0]       r_cnt;
    logic                       r_we;
    logic [ADDRESS_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic [ADDRESS_WIDTH-1:0]   r_fill_addr;
    logic [DATA_WIDTH-1:0]      r_fill_data;
    logic                       r_err;
    logic                       w_timeout;

    assign w_timeout = (r_state == ST_REQ) && !mem_ready_i && (r_cnt == c_TIMEOUT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (miss_i) w_next_state = ST_REQ;
            ST_REQ:  if (mem_ready_i || w_timeout) w_next_state = ST_FILL;
            ST_FILL: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o    = (r_state == ST_REQ);
        mem_we_o     = (r_state == ST_REQ) && r_we;
        fill_valid_o = (r_state == ST_FILL);
        stall_o      = miss_i || (r_state != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_fill_addr <= '0;
            r_fill_data <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (miss_i) begin
                        r_cnt   <= '0;
                        r_we    <= we_i;
                        r_addr  <= {addr_i[ADDRESS_WIDTH-1:2], 2'b00};
                        r_wdata <= wdata_i;
                    end
                end
                ST_REQ: begin
                    // Ready wins over a simultaneous timeout.
                    if (mem_ready_i) begin
                        r_fill_addr <= r_addr;
                        r_fill_data <= r_we ? r_wdata : mem_rdata_i;
                    end else if (w_timeout) begin
                        r_fill_addr <= r_addr;
                        r_fill_data <= '0;
                        r_err       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign fill_addr_o = r_fill_addr;
    assign fill_data_o = r_fill_data;
    assign err_o       = r_err;

endmodule : mem_refill_ctrl
`default_nettype wire

// File: tb/tb_mem_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_refill_ctrl
// Description : Scoreboard bench for mem_refill_ctrl with a cycle-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_refill_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        miss_i, we_i, mem_ready_i;
    logic [31:0] addr_i, wdata_i, mem_rdata_i;
    logic        mem_req_o, mem_we_o, fill_valid_o, stall_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, fill_addr_o, fill_data_o;

    mem_refill_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .miss_i(miss_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
        .mem_rdata_i(mem_rdata_i), .fill_valid_o(fill_valid_o), .fill_addr_o(fill_addr_o),
        .fill_data_o(fill_data_o), .stall_o(stall_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } fill_t;

    fill_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        mon_en   = 1'b0;
    logic        exp_req, exp_fill, exp_stall, exp_err, exp_we;
    logic [31:0] exp_addr, exp_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle protocol checks plus scoreboard pop on each fill strobe.
    always @(negedge clk_i) begin
        if (mon_en) begin
            fill_t f;
            chk("stall", 32'(stall_o), 32'(exp_stall));
            chk("mem_req", 32'(mem_req_o), 32'(exp_req));
            chk("fill_valid", 32'(fill_valid_o), 32'(exp_fill));
            chk("err", 32'(err_o), 32'(exp_err));
            if (exp_req) begin
                chk("mem_addr", mem_addr_o, exp_addr);
                chk("mem_we", 32'(mem_we_o), 32'(exp_we));
                chk("mem_wdata", mem_wdata_o, exp_wdata);
            end
            if (fill_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("fill_unexpected", 32'(fill_valid_o), 32'd0);
                end else begin
                    f = exp_q.pop_front();
                    chk("fill_addr", fill_addr_o, f.addr);
                    chk("fill_data", fill_data_o, f.data);
                    chk("fill_err", 32'(err_o), 32'(f.err));
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            miss_i      = 1'b0;
            we_i        = 1'($urandom_range(0, 1));
            addr_i      = $urandom;
            mem_ready_i = 1'($urandom_range(0, 1));
            mem_rdata_i = $urandom;
            exp_req = 1'b0; exp_fill = 1'b0; exp_stall = 1'b0;
        end
    endtask

    // lat: number of REQ cycles before ready; negative means memory never answers.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int lat);
        int   n;
        logic tmo;
        tmo = (lat < 0) || (lat > 254);
        n   = tmo ? 255 : lat + 1;
        @(posedge clk_i); #1;
        miss_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
        mem_ready_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
        exp_req = 1'b0; exp_fill = 1'b0; exp_stall = 1'b1;
        exp_addr = addr & 32'hFFFF_FFFC; exp_we = we; exp_wdata = wdata;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            miss_i  = 1'($urandom_range(0, 1));
            we_i    = 1'($urandom_range(0, 1));
            addr_i  = $urandom;
            wdata_i = $urandom;
            exp_req = 1'b1; exp_stall = 1'b1;
            if (i == lat) begin
                mem_ready_i = 1'b1; mem_rdata_i = rdata;
            end else begin
                mem_ready_i = 1'b0; mem_rdata_i = $urandom;
            end
        end
        @(posedge clk_i); #1;
        miss_i = 1'b0; mem_ready_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
        exp_req = 1'b0; exp_fill = 1'b1; exp_stall = 1'b1;
        if (tmo) exp_err = 1'b1;
        exp_q.push_back('{addr: exp_addr, data: tmo ? 32'd0 : (we ? wdata : rdata), err: exp_err});
    endtask

    task automatic reset_mid_req();
        @(posedge clk_i); #1;
        miss_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0310; wdata_i = 32'h0;
        mem_ready_i = 1'b0;
        exp_stall = 1'b1; exp_fill = 1'b0; exp_req = 1'b0;
        exp_addr = 32'h0000_0310; exp_we = 1'b0; exp_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            miss_i = 1'b0; addr_i = $urandom; mem_ready_i = 1'b0;
            exp_req = 1'b1; exp_stall = 1'b1;
        end
        #2;
        rst_i = 1'b1;
        exp_req = 1'b0; exp_stall = 1'b0; exp_err = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        @(posedge clk_i); #1;
        mem_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        idle(4);
    endtask

    initial begin
        rst_i = 1'b1; miss_i = 1'b1; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        mem_ready_i = 1'b0; mem_rdata_i = '0;
        exp_req = 1'b0; exp_fill = 1'b0; exp_stall = 1'b0; exp_err = 1'b0;
        exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
        #1;
        chk("reset_mem_req", 32'(mem_req_o), 32'd0);
        chk("reset_mem_we", 32'(mem_we_o), 32'd0);
        chk("reset_mem_addr", mem_addr_o, 32'd0);
        chk("reset_mem_wdata", mem_wdata_o, 32'd0);
        chk("reset_fill_valid", 32'(fill_valid_o), 32'd0);
        chk("reset_fill_addr", fill_addr_o, 32'd0);
        chk("reset_fill_data", fill_data_o, 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        chk("reset_stall_miss1", 32'(stall_o), 32'd1);
        miss_i = 1'b0;
        #1;
        chk("reset_stall_miss0", 32'(stall_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        mon_en = 1'b1;

        txn(1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 3);
        idle(1);
        txn(1'b1, 32'h0000_0207, 32'h1234_5678, 32'hFFFF_0000, 0);
        txn(1'b0, 32'h0000_0400, 32'h0, 32'hA5A5_A5A5, 254);
        idle(2);
        txn(1'b0, 32'h0000_0500, 32'h0, 32'h5555_AAAA, -1);
        idle(2);
        for (int t = 0; t < 40; t++) begin
            int r, lat;
            r   = int'($urandom_range(0, 11));
            lat = (r == 0) ? -1 : (r == 1) ? 254 : int'($urandom_range(0, 6));
            txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, lat);
            idle(int'($urandom_range(0, 2)));
        end
        reset_mid_req();
        txn(1'b1, 32'h0000_0A0B, 32'hCAFE_F00D, 32'h0, 1);
        idle(3);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_refill_ctrl
`default_nettype wire

// File: doc/mem_refill_ctrl.md
MEM_REFILL_CTRL -- requirements
Module: mem_refill_ctrl

Interface
REQ-001 Parameter SHALL be: ADDRESS_WIDTH, 32, address width.
REQ-002 Parameter SHALL be: DATA_WIDTH, 32, data word width.
REQ-003 Parameter SHALL be: TIMEOUT_CYCLES, 255, maximum REQ-state cycles before abort (fits in 8 bits).
REQ-004 Port SHALL be: clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 Port SHALL be: rst_i  input  1  reset, asynchronous, active-high.
REQ-006 Port SHALL be: miss_i  input  1  cache miss, level signal, from the data cache.
REQ-007 Port SHALL be: we_i  input  1  the missing access is a store (MemWriteM).
REQ-008 Port SHALL be: addr_i  input  ADDRESS_WIDTH  address of the missing access.
REQ-009 Port SHALL be: wdata_i  input  DATA_WIDTH  store data of the missing access.
REQ-010 Port SHALL be: mem_req_o  output  1  memory request valid.
REQ-011 Port SHALL be: mem_we_o  output  1  memory request is a write.
REQ-012 Port SHALL be: mem_addr_o  output  ADDRESS_WIDTH  word-aligned memory address.
REQ-013 Port SHALL be: mem_wdata_o  output  DATA_WIDTH  memory write data.
REQ-014 Port SHALL be: mem_ready_i  input  1  memory completes request this cycle.
REQ-015 Port SHALL be: mem_rdata_i  input  DATA_WIDTH  memory read data, valid when mem_ready_i=1.
REQ-016 Port SHALL be: fill_valid_o  output  1  one-cycle cache fill strobe.
REQ-017 Port SHALL be: fill_addr_o  output  ADDRESS_WIDTH  address of fill line.
REQ-018 Port SHALL be: fill_data_o  output  DATA_WIDTH  fill word.
REQ-019 Port SHALL be: stall_o  output  1  pipeline stall request.
REQ-020 Port SHALL be: err_o  output  1  sticky timeout error.

Function
REQ-021 FSM SHALL have states IDLE, REQ, FILL.
REQ-022 IDLE with miss_i=1 SHALL capture addr_i (bits [1:0] forced 0), we_i, wdata_i and move to REQ; otherwise remain IDLE.
REQ-023 In REQ, mem_req_o=1, mem_we_o=captured we, mem_addr_o/mem_wdata_o=captured values, all stable until completion.
REQ-024 REQ with mem_ready_i=1 SHALL move to FILL; fill data = mem_rdata_i for reads, captured wdata for writes (write-through, write-allocate).
REQ-025 mem_ready_i SHALL be honoured in the first REQ cycle; minimum miss-to-fill latency = 2 cycles (miss at cycle 0, fill_valid_o at cycle 2).
REQ-026 8-bit wait counter SHALL clear on IDLE->REQ and increment each REQ cycle without mem_ready_i.
REQ-027 Counter reaching TIMEOUT_CYCLES in REQ without mem_ready_i SHALL set err_o, move to FILL with fill data 0.
REQ-028 mem_ready_i in the same cycle as timeout SHALL take priority (normal completion, no error).
REQ-029 FILL SHALL assert fill_valid_o for exactly one cycle with registered fill_addr_o/fill_data_o, then return to IDLE.
REQ-030 stall_o SHALL equal miss_i OR (state != IDLE).
REQ-031 miss_i, addr_i, we_i, wdata_i SHALL be ignored in REQ and FILL.
REQ-032 mem_ready_i outside REQ SHALL be ignored.
REQ-033 err_o SHALL remain 1 until reset.

Reset
REQ-034 rst_i=1 SHALL immediately force IDLE, counter 0, captured regs 0, err_o 0, independent of clk_i.
REQ-035 Reset value of all outputs SHALL be 0, except stall_o, which follows miss_i combinationally.
REQ-036 Reset asserted during REQ SHALL drop mem_req_o immediately; no fill SHALL follow.

Structure
REQ-037 State enum and TIMEOUT_CYCLES default SHALL live in shared package refill_pkg.
REQ-038 Block SHALL be a single module; no sub-module.

Verification
REQ-039 Read miss addr 0x0000_0104, mem_ready_i 3 cycles after request with rdata 0xDEAD_BEEF -> fill_valid_o one cycle, fill_addr_o 0x104, fill_data_o 0xDEAD_BEEF, mem_we_o=0.
REQ-040 Write miss addr 0x0000_0207, wdata 0x1234_5678, ready in first REQ cycle -> mem_we_o=1, mem_addr_o 0x204, fill at cycle 2 with 0x1234_5678.
REQ-041 mem_ready_i never asserted -> err_o=1 after 255 REQ cycles, fill_data_o 0, return IDLE, err_o stays 1.
REQ-042 mem_ready_i in timeout cycle with rdata 0xA5A5_A5A5 -> err_o=0, fill 0xA5A5_A5A5.
REQ-043 Assert rst_i mid-REQ between clock edges -> mem_req_o, stall (with miss_i=0) drop same cycle; no fill_valid_o.
REQ-044 Change addr_i/we_i during REQ -> mem_addr_o, mem_we_o unchanged; stall_o=1 throughout REQ and FILL.
